// File: rtl/tile_bram_pkg.sv
// tile_bram_pkg: shared read-FSM state encoding and wrapping address helper
// for the tile stream buffer.
package tile_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STREAM
    } rd_state_e;

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic int unsigned next_addr(input int unsigned a, input int unsigned depth);
        return (a == depth - 1) ? 0 : a + 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read-first
// read port; only the read register is reset, never the array.
module sdp_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tile_stream_bram.sv
// tile_stream_bram: sequential-fill vector buffer that replays a contiguous,
// optionally wrapping, window of stored elements as a burst with a last marker.
module tile_stream_bram
    import tile_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int WRAP_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  full,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH:0]   rd_len,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_err
);

    localparam logic [ADDR_WIDTH+1:0] DEPTH_X = (ADDR_WIDTH + 2)'(DEPTH);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nx;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  wr_en, re, bad;
    logic [ADDR_WIDTH+1:0] len_x, base_x, end_x;

    assign full       = fill_q == DEPTH_X[ADDR_WIDTH:0];
    assign wr_ready   = !full;
    assign fill_count = fill_q;
    assign rd_busy    = state_q != ST_IDLE;
    assign rd_valid   = valid_q;
    assign rd_last    = valid_q && rem_q == (ADDR_WIDTH + 1)'(1);
    assign rd_err     = err_q;
    assign wr_en      = wr_valid && !full && !clear;
    assign addr_nx    = ADDR_WIDTH'(next_addr(32'(addr_q), DEPTH));

    always_comb begin
        len_x  = {1'b0, rd_len};
        base_x = (ADDR_WIDTH + 2)'(rd_base);
        end_x  = base_x + len_x;
        bad    = len_x == '0 || len_x > DEPTH_X || base_x >= DEPTH_X ||
                 (WRAP_EN == 0 && end_x > DEPTH_X);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        re      = 1'b0;
        fill_d  = fill_q + (ADDR_WIDTH + 1)'(wr_en);
        case (state_q)
            ST_IDLE: begin
                if (rd_start && !clear) begin
                    err_d   = bad;
                    state_d = bad ? ST_IDLE : ST_ADDR;
                    addr_d  = bad ? addr_q : rd_base;
                    rem_d   = bad ? rem_q : rd_len;
                end
            end
            ST_ADDR: begin
                re      = 1'b1;
                addr_d  = addr_nx;
                valid_d = 1'b1;
                state_d = ST_STREAM;
            end
            default: begin
                // The final element needs no further RAM read, so rd_data holds it.
                if (rem_q == (ADDR_WIDTH + 1)'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    re      = 1'b1;
                    addr_d  = addr_nx;
                    rem_d   = rem_q - 1'b1;
                    valid_d = 1'b1;
                end
            end
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            fill_d  = '0;
            re      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_en),
        .waddr(fill_q[ADDR_WIDTH-1:0]),
        .wdata(wr_data),
        .re   (re),
        .raddr(addr_q),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_tile_stream_bram.sv
// tb_tile_stream_bram: directed bench; u0 wraps (DEPTH 8), u1 rejects wrapping
// bursts (DEPTH 8), u2 has DEPTH 6 so out-of-range bases are expressible.
module tb_tile_stream_bram;

    logic        clk = 1'b0, rst = 1'b1, clear = 1'b0, wr_valid = 1'b0, rd_start = 1'b0;
    logic [11:0] wr_data = '0;
    logic [2:0]  rd_base = '0;
    logic [3:0]  rd_len = '0;

    logic        wr_ready0, full0, busy0, valid0, last0, err0;
    logic        wr_ready1, full1, busy1, valid1, last1, err1;
    logic        wr_ready2, full2, busy2, valid2, last2, err2;
    logic [3:0]  fill0, fill1, fill2;
    logic [11:0] data0, data1, data2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tile_stream_bram #(.DATA_WIDTH(12), .DEPTH(8), .WRAP_EN(1)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready0), .fill_count(fill0), .full(full0), .rd_start(rd_start),
        .rd_base(rd_base), .rd_len(rd_len), .rd_busy(busy0), .rd_valid(valid0),
        .rd_data(data0), .rd_last(last0), .rd_err(err0));

    tile_stream_bram #(.DATA_WIDTH(12), .DEPTH(8), .WRAP_EN(0)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready1), .fill_count(fill1), .full(full1), .rd_start(rd_start),
        .rd_base(rd_base), .rd_len(rd_len), .rd_busy(busy1), .rd_valid(valid1),
        .rd_data(data1), .rd_last(last1), .rd_err(err1));

    tile_stream_bram #(.DATA_WIDTH(12), .DEPTH(6), .WRAP_EN(1)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready2), .fill_count(fill2), .full(full2), .rd_start(rd_start),
        .rd_base(rd_base), .rd_len(rd_len), .rd_busy(busy2), .rd_valid(valid2),
        .rd_data(data2), .rd_last(last2), .rd_err(err2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (fill0 !== 4'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fill0); end
        n_cmp++; if (full0 !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full0); end
        n_cmp++; if (wr_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_cmp++; if ({valid0, last0, err0} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {valid0, last0, err0}); end
        n_cmp++; if (data0 !== 12'h000) begin n_err++; $display("FAIL reset_data: got %h want 000", data0); end
        n_cmp++; if ({busy1, valid1, busy2, valid2} !== 4'b0000) begin n_err++; $display("FAIL reset_others: got %b want 0000", {busy1, valid1, busy2, valid2}); end
    endtask

    task automatic test_fill();
        wr_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wr_data = 12'(i);
            step();
            n_cmp++; if (fill0 !== 4'((i > 8) ? 8 : i)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, fill0, (i > 8) ? 8 : i); end
            n_cmp++; if (wr_ready0 !== (i < 8)) begin n_err++; $display("FAIL fill_wr_ready[%0d]: got %b want %b", i, wr_ready0, i < 8); end
        end
        wr_valid = 1'b0;
        n_cmp++; if (full0 !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full0); end
        n_cmp++; if (fill2 !== 4'd6 || full2 !== 1'b1) begin n_err++; $display("FAIL fill_depth6: got %0d/%b want 6/1", fill2, full2); end
    endtask

    // Buffer holds 1..8 at addresses 0..7, so element at address a is a+1.
    task automatic run_burst(input logic [2:0] base, input logic [3:0] len, input bit u1_err, input bit poke);
        logic [11:0] exp;
        exp = '0;
        rd_base = base; rd_len = len; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        n_cmp++; if (busy0 !== 1'b1 || valid0 !== 1'b0) begin n_err++; $display("FAIL burst_c1: got busy %b valid %b want 1 0", busy0, valid0); end
        if (u1_err) begin
            n_cmp++; if (err1 !== 1'b1 || busy1 !== 1'b0) begin n_err++; $display("FAIL nowrap_err: got err %b busy %b want 1 0", err1, busy1); end
        end else begin
            n_cmp++; if (busy1 !== 1'b1 || err0 !== 1'b0) begin n_err++; $display("FAIL burst_c1_u1: got busy %b err %b want 1 0", busy1, err0); end
        end
        if (poke) begin rd_start = 1'b1; rd_len = 4'd0; end
        for (int k = 0; k < int'(len); k++) begin
            step();
            rd_start = 1'b0;
            exp = 12'(((int'(base) + k) % 8) + 1);
            n_cmp++; if (valid0 !== 1'b1 || data0 !== exp) begin n_err++; $display("FAIL burst_data[%0d]: got v%b %0d want v1 %0d", k, valid0, data0, exp); end
            n_cmp++; if (last0 !== (k == int'(len) - 1) || err0 !== 1'b0) begin n_err++; $display("FAIL burst_last[%0d]: got last %b err %b want %b 0", k, last0, err0, k == int'(len) - 1); end
            if (u1_err) begin
                n_cmp++; if (valid1 !== 1'b0 || err1 !== 1'b0) begin n_err++; $display("FAIL nowrap_quiet[%0d]: got valid %b err %b want 0 0", k, valid1, err1); end
            end else begin
                n_cmp++; if (valid1 !== 1'b1 || data1 !== exp) begin n_err++; $display("FAIL burst_u1[%0d]: got v%b %0d want v1 %0d", k, valid1, data1, exp); end
            end
        end
        step();
        n_cmp++; if (busy0 !== 1'b0 || valid0 !== 1'b0 || last0 !== 1'b0) begin n_err++; $display("FAIL burst_end: got busy %b valid %b last %b want 0 0 0", busy0, valid0, last0); end
        n_cmp++; if (data0 !== exp) begin n_err++; $display("FAIL burst_hold: got %0d want %0d", data0, exp); end
    endtask

    task automatic test_back_to_back();
        run_burst(3'd0, 4'd3, 1'b0, 1'b1);
        run_burst(3'd5, 4'd2, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        for (int i = 0; i < 2; i++) begin
            rd_base = 3'd0; rd_len = (i == 0) ? 4'd0 : 4'd9; rd_start = 1'b1;
            step();
            rd_start = 1'b0;
            n_cmp++; if (err0 !== 1'b1 || err1 !== 1'b1 || busy0 !== 1'b0) begin n_err++; $display("FAIL err_len%0d: got err %b%b busy %b want 11 0", rd_len, err0, err1, busy0); end
            step();
            n_cmp++; if (err0 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL err_pulse%0d: got err %b busy %b want 0 0", rd_len, err0, busy0); end
        end
        rd_base = 3'd6; rd_len = 4'd1; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        n_cmp++; if (err2 !== 1'b1 || busy2 !== 1'b0) begin n_err++; $display("FAIL err_base: got err %b busy %b want 1 0", err2, busy2); end
        n_cmp++; if (busy0 !== 1'b1 || err0 !== 1'b0) begin n_err++; $display("FAIL base_ok_d8: got busy %b err %b want 1 0", busy0, err0); end
        step();
        n_cmp++; if (err2 !== 1'b0 || busy2 !== 1'b0) begin n_err++; $display("FAIL err_base_pulse: got err %b busy %b want 0 0", err2, busy2); end
        n_cmp++; if (valid0 !== 1'b1 || data0 !== 12'd7 || last0 !== 1'b1) begin n_err++; $display("FAIL base6_len1: got v%b %0d l%b want v1 7 l1", valid0, data0, last0); end
        step();
    endtask

    task automatic test_abort();
        rd_base = 3'd0; rd_len = 4'd6; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        step();
        n_cmp++; if (valid0 !== 1'b1 || data0 !== 12'd2) begin n_err++; $display("FAIL abort_pre: got v%b %0d want v1 2", valid0, data0); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++; if (valid0 !== 1'b0 || last0 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL abort_stop: got v%b l%b b%b want 000", valid0, last0, busy0); end
        n_cmp++; if (fill0 !== 4'd0 || wr_ready0 !== 1'b1) begin n_err++; $display("FAIL abort_fill: got %0d rdy %b want 0 1", fill0, wr_ready0); end
        rd_base = 3'd0; rd_len = 4'd2; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL abort_restart: got busy %b want 1", busy0); end
        step();
        n_cmp++; if (valid0 !== 1'b1 || data0 !== 12'd1) begin n_err++; $display("FAIL abort_stale0: got v%b %0d want v1 1", valid0, data0); end
        step();
        n_cmp++; if (data0 !== 12'd2 || last0 !== 1'b1) begin n_err++; $display("FAIL abort_stale1: got %0d l%b want 2 l1", data0, last0); end
        step();
    endtask

    task automatic test_async_reset();
        rd_base = 3'd0; rd_len = 4'd6; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        n_cmp++; if (valid0 !== 1'b1) begin n_err++; $display("FAIL areset_pre: got valid %b want 1", valid0); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({busy0, valid0, last0, err0} !== 4'b0000) begin n_err++; $display("FAIL areset_flags: got %b want 0000", {busy0, valid0, last0, err0}); end
        n_cmp++; if (data0 !== 12'h000 || fill0 !== 4'd0 || wr_ready0 !== 1'b1) begin n_err++; $display("FAIL areset_state: got %h %0d %b want 000 0 1", data0, fill0, wr_ready0); end
        #2 rst = 1'b0;
        step();
        wr_valid = 1'b1; wr_data = 12'hABC;
        step();
        wr_valid = 1'b0;
        n_cmp++; if (fill0 !== 4'd1) begin n_err++; $display("FAIL areset_write: got fill %0d want 1", fill0); end
        rd_base = 3'd0; rd_len = 4'd1; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        n_cmp++; if (valid0 !== 1'b1 || data0 !== 12'hABC || last0 !== 1'b1) begin n_err++; $display("FAIL areset_read: got v%b %h l%b want v1 abc l1", valid0, data0, last0); end
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        step();
        test_fill();
        run_burst(3'd2, 4'd4, 1'b0, 1'b0);
        run_burst(3'd6, 4'd4, 1'b1, 1'b0);
        test_back_to_back();
        test_errors();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
